spm_sequencer: RTL and testbench
================================

SPM_SEQUENCER -- requirements
Module: spm_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits, equal to the parallel x width of the attached spm.
REQ-002 SHALL have parameter SPM_LAT, default 1: cycles from driving bit k on spm_y to bit k of the product on spm_p.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: operand pair offered.
REQ-006 SHALL have port in_ready, output, 1 bit: sequencer accepts operands.
REQ-007 SHALL have port in_x, input, WIDTH bits: parallel multiplicand.
REQ-008 SHALL have port in_y, input, WIDTH bits: multiplier, to be serialised.
REQ-009 SHALL have port spm_x, output, WIDTH bits: registered multiplicand to the spm x input.
REQ-010 SHALL have port spm_y, output, 1 bit: serial multiplier stream, LSB first.
REQ-011 SHALL have port spm_clr, output, 1 bit: spm clear pulse, ORed with rst at the spm.
REQ-012 SHALL have port spm_p, input, 1 bit: serial product from the spm, LSB first.
REQ-013 SHALL have port out_valid, output, 1 bit: product available.
REQ-014 SHALL have port out_ready, input, 1 bit: consumer accepts the product.
REQ-015 SHALL have port out_p, output, 2*WIDTH bits: assembled product.

Function
REQ-016 SHALL implement the FSM states IDLE, CLEAR, SHIFT and DONE.
REQ-017 In IDLE: in_ready=1; in_valid=1 latches in_x into spm_x and in_y into the y shift register, then goes to CLEAR.
REQ-018 CLEAR SHALL last exactly 1 cycle with spm_clr=1 and spm_y=0, then go to SHIFT with cnt=0.
REQ-019 SHIFT SHALL last 2*WIDTH+SPM_LAT cycles:
  - spm_y = y-register LSB, and the register shifts right each cycle.
  - For cnt>=WIDTH, spm_y = fill bit (REQ-028).
REQ-020 SHALL shift spm_p into the MSB of the product register only while cnt>=SPM_LAT, so that exactly 2*WIDTH bits are captured; out_p bit 0 is the first captured bit.
REQ-021 SHALL leave SHIFT when cnt=2*WIDTH+SPM_LAT-1 and enter DONE with out_valid=1.
REQ-022 In DONE: out_valid=1 and out_p stable until out_ready=1; the handshake cycle returns to IDLE.
REQ-023 in_ready SHALL be 0 in CLEAR, SHIFT and DONE; there is no same-cycle accept on the DONE exit.
REQ-024 The counter SHALL be $clog2(2*WIDTH+SPM_LAT+1) bits wide; count SHALL not wrap.
REQ-025 Latency from the accept cycle to out_valid SHALL be 2*WIDTH+SPM_LAT+2 cycles.
REQ-026 spm_x and out_p SHALL hold their value until the next accept.

Reset
REQ-027 On rst=1, at any state including mid-SHIFT, SHALL:
  - go to IDLE and discard the operation in flight;
  - drive in_ready=1 on the next cycle;
  - clear out_valid, spm_clr, spm_y, cnt, spm_x and out_p to 0.

Configuration
REQ-028 Macro SPM_SEQ_SIGNED_EN:
  - Defined: fill bit = in_y[WIDTH-1] as latched, giving a two's-complement product.
  - Undefined: fill bit = 0, giving an unsigned product.

Structure
REQ-029 Package spm_pkg SHALL hold the state enum spm_seq_state_t and the counter-width function.
REQ-030 The parallel-in/serial-out y register SHALL be sub-module spm_seq_piso; product capture SHALL stay inline.

Verification
REQ-031 The bench SHALL use WIDTH=8, SPM_LAT=1 and a behavioural serial spm model, and SHALL cover these scenarios:
  - in_x=3, in_y=5, out_ready=1 -> out_p=15, out_valid exactly 19 cycles after accept, lasting 1 cycle.
  - in_x=255, in_y=255, macro undefined -> out_p=65025.
  - in_x=8'hFF, in_y=8'hFF, SPM_SEQ_SIGNED_EN defined -> out_p=16'h0001.
  - out_ready held 0 for 10 cycles in DONE -> out_valid and out_p=15 stable; in_ready=0 throughout; IDLE follows the handshake.
  - rst pulsed at SHIFT cnt=6 -> next cycle IDLE with in_ready=1 and out_valid=0; new operands 7*9 -> out_p=63.
  - Back-to-back in_valid=1 with 2*3, then 4*5 -> products 6 and 20 in order; second accept one cycle after the first DONE handshake.

Source files
------------

// File: rtl/spm_pkg.sv
// Shared types and helpers for the serial-parallel multiplier sequencer.
// Build option: SPM_SEQ_SIGNED_EN (see spm_sequencer.sv).
package spm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } spm_seq_state_t;

    // Counter width able to hold every value from 0 to 2*width+lat inclusive.
    function automatic int spm_cnt_w(input int width, input int lat);
        return $clog2(2 * width + lat + 1);
    endfunction

endpackage

// File: rtl/spm_seq_piso.sv
// Parallel-in / serial-out multiplier register, LSB first.
// On each shift the fill bit enters at the MSB, so after WIDTH shifts the
// LSB already carries the extension bit of the multiplier.
module spm_seq_piso #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             shift,
    input  logic             fill,
    output logic             lsb
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // Load takes priority over shift; otherwise the register holds.
    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = d;
        end else if (shift) begin
            sr_d = {fill, sr_q[WIDTH-1:1]};
        end
    end

    // Data-only register: its content is always reloaded before use.
    always_ff @(posedge clk) begin
        sr_q <= sr_d;
    end

    assign lsb = sr_q[0];

endmodule

// File: rtl/spm_sequencer.sv
// Sequencer for a serial-parallel multiplier (spm): latches an operand pair,
// clears the spm, streams the multiplier LSB first (2*WIDTH bits, extended
// with a fill bit) and assembles the 2*WIDTH-bit serial product.
// Build option: define SPM_SEQ_SIGNED_EN to sign-extend the multiplier
// stream (two's-complement product); default is zero fill (unsigned).
module spm_sequencer
    import spm_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SPM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_x,
    input  logic [WIDTH-1:0]   in_y,
    output logic [WIDTH-1:0]   spm_x,
    output logic               spm_y,
    output logic               spm_clr,
    input  logic               spm_p,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p
);

    localparam int CNT_W = spm_cnt_w(WIDTH, SPM_LAT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * WIDTH + SPM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_FILL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(SPM_LAT);

    spm_seq_state_t     state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   spm_x_q, spm_x_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               load;
    logic               shift;
    logic               y_lsb;
    logic               fill_bit;
    logic               accept;

    assign accept = (state_q == IDLE) && in_valid;

`ifdef SPM_SEQ_SIGNED_EN
    logic fill_q, fill_d;

    // Remember the multiplier sign at accept; it extends the serial stream.
    always_comb begin
        fill_d = fill_q;
        if (accept) begin
            fill_d = in_y[WIDTH-1];
        end
    end

    // Sign-bit register, cleared with the rest of the control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q <= 1'b0;
        end else begin
            fill_q <= fill_d;
        end
    end

    assign fill_bit = fill_q;
`else
    assign fill_bit = 1'b0;
`endif

    spm_seq_piso #(
        .WIDTH(WIDTH)
    ) u_piso (
        .clk  (clk),
        .load (load),
        .d    (in_y),
        .shift(shift),
        .fill (fill_bit),
        .lsb  (y_lsb)
    );

    // Next-state, counter and product-capture logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        spm_x_d = spm_x_q;
        prod_d  = prod_q;
        load    = 1'b0;
        shift   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    spm_x_d = in_x;
                    load    = 1'b1;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                shift = 1'b1;
                // The first SPM_LAT samples predate product bit 0.
                if (cnt_q >= CNT_CAP) begin
                    prod_d = {spm_p, prod_q[2*WIDTH-1:1]};
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            spm_x_q <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            spm_x_q <= spm_x_d;
            prod_q  <= prod_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign spm_clr   = (state_q == CLEAR);
    assign out_valid = (state_q == DONE);
    assign spm_x     = spm_x_q;
    assign out_p     = prod_q;
    assign spm_y     = (state_q != SHIFT) ? 1'b0 :
                       (cnt_q < CNT_FILL)  ? y_lsb : fill_bit;

endmodule

// File: tb/tb_spm_sequencer.sv
// Bench for spm_sequencer (WIDTH=8, SPM_LAT=1) with a behavioural serial
// multiplier attached. Honors SPM_SEQ_SIGNED_EN for expected products.
module tb_spm_sequencer;

    localparam int W       = 8;
    localparam int LAT     = 1;
    localparam int LATENCY = 2 * W + LAT + 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_x;
    logic [W-1:0]   in_y;
    logic [W-1:0]   spm_x;
    logic           spm_y;
    logic           spm_clr;
    logic           spm_p;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_p;

    int tests = 0;
    int fails = 0;

    longint acc;

    always #5 clk = ~clk;

    spm_sequencer #(
        .WIDTH  (W),
        .SPM_LAT(LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x     (in_x),
        .in_y     (in_y),
        .spm_x    (spm_x),
        .spm_y    (spm_y),
        .spm_clr  (spm_clr),
        .spm_p    (spm_p),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_p    (out_p)
    );

    // Serial-parallel multiplier: add x when the y bit is 1, emit the LSB
    // one cycle later, keep the rest as the running partial sum.
    function automatic longint spm_sum(input longint a, input logic yb, input logic [W-1:0] x);
        longint xe;
`ifdef SPM_SEQ_SIGNED_EN
        xe = longint'($signed(x));
`else
        xe = longint'(x);
`endif
        return a + (yb ? xe : 64'sd0);
    endfunction

    function automatic logic spm_bit(input longint a, input logic yb, input logic [W-1:0] x);
        longint s;
        s = spm_sum(a, yb, x);
        return s[0];
    endfunction

    always @(posedge clk) begin
        if (rst || spm_clr) begin
            acc   <= 64'sd0;
            spm_p <= 1'b0;
        end else begin
            acc   <= spm_sum(acc, spm_y, spm_x) >>> 1;
            spm_p <= spm_bit(acc, spm_y, spm_x);
        end
    end

    // Reference product: plain arithmetic, truncated to 2*W bits.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        int p;
`ifdef SPM_SEQ_SIGNED_EN
        p = int'($signed(x)) * int'($signed(y));
`else
        p = int'(x) * int'(y);
`endif
        return p[2*W-1:0];
    endfunction

    typedef struct {
        logic [W-1:0]   x;
        logic [W-1:0]   y;
        logic [2*W-1:0] exp_u;
        logic [2*W-1:0] exp_s;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction from IDLE; hold = cycles out_ready stays low in DONE.
    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int hold, input logic [2*W-1:0] exp);
        int lat;
        check({tag, "_in_ready_idle"}, in_ready, 1);
        in_x      = x;
        in_y      = y;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        lat      = 1;
        check({tag, "_clr_pulse"}, spm_clr, 1);
        check({tag, "_y_in_clear"}, spm_y, 0);
        check({tag, "_in_ready_busy"}, in_ready, 0);
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, LATENCY);
        for (int i = 0; i < hold; i++) begin
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_p"}, out_p, exp);
            check({tag, "_hold_in_ready"}, in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        check({tag, "_p"}, out_p, exp);
        check({tag, "_x_held"}, spm_x, x);
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_back_idle"}, in_ready, 1);
        check({tag, "_p_kept"}, out_p, exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2*W-1:0] e;
        logic [W-1:0]   rx, ry;
        int             lat;

        vecs[0] = '{8'd3,   8'd5,   16'd15,    16'd15};
        vecs[1] = '{8'd255, 8'd255, 16'd65025, 16'h0001};
        vecs[2] = '{8'd7,   8'd9,   16'd63,    16'd63};
        vecs[3] = '{8'd2,   8'd3,   16'd6,     16'd6};
        vecs[4] = '{8'd4,   8'd5,   16'd20,    16'd20};
        vecs[5] = '{8'd0,   8'd200, 16'd0,     16'd0};
        vecs[6] = '{8'd128, 8'd2,   16'd256,   16'hFF00};
        vecs[7] = '{8'd1,   8'd255, 16'd255,   16'hFFFF};
        vecs[8] = '{8'd255, 8'd1,   16'd255,   16'hFFFF};
        vecs[9] = '{8'd170, 8'd85,  16'd14450, 16'd58226};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_x      = '0;
        in_y      = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_p", out_p, 0);
        check("rst_spm_x", spm_x, 0);
        check("rst_spm_clr", spm_clr, 0);
        check("rst_spm_y", spm_y, 0);
        tick();

        // Table of directed products.
        for (int i = 0; i < 10; i++) begin
`ifdef SPM_SEQ_SIGNED_EN
            e = vecs[i].exp_s;
`else
            e = vecs[i].exp_u;
`endif
            run_op($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, 0, e);
        end

        // Consumer stalls for 10 cycles in DONE.
        run_op("hold", 8'd3, 8'd5, 10, 16'd15);

        // Back-to-back: in_valid never drops, second accept follows the handshake.
        in_x      = 8'd2;
        in_y      = 8'd3;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check("b2b_ready0", in_ready, 1);
        tick();
        lat  = 1;
        in_x = 8'd4;
        in_y = 8'd5;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        check("b2b_lat0", lat, LATENCY);
        check("b2b_p0", out_p, 6);
        check("b2b_no_accept_in_done", in_ready, 0);
        tick();
        check("b2b_idle_valid", out_valid, 0);
        check("b2b_idle_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        lat      = 1;
        check("b2b_second_accept", spm_clr, 1);
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        check("b2b_lat1", lat, LATENCY);
        check("b2b_p1", out_p, 20);
        tick();
        out_ready = 1'b0;
        check("b2b_done_valid", out_valid, 0);

        // Reset in the middle of SHIFT (cnt=6 is the 8th cycle after accept).
        in_x     = 8'd100;
        in_y     = 8'd100;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        check("mid_busy", in_ready, 0);
        rst = 1'b1;
        tick();
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_p", out_p, 0);
        check("mid_rst_spm_x", spm_x, 0);
        check("mid_rst_spm_y", spm_y, 0);
        check("mid_rst_spm_clr", spm_clr, 0);
        rst = 1'b0;
        tick();
        run_op("after_rst", 8'd7, 8'd9, 0, 16'd63);

        // Randomized operands against the arithmetic reference.
        for (int i = 0; i < 30; i++) begin
            rx = W'($urandom_range(0, 255));
            ry = W'($urandom_range(0, 255));
            repeat ($urandom_range(0, 2)) tick();
            run_op($sformatf("rnd%0d", i), rx, ry, int'($urandom_range(0, 2)), ref_mul(rx, ry));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
